// File: rtl/led_scan_ctrl.sv
// LED bar scan sequencer for a 3-to-8 one-hot decoder: tick prescaler, IDLE/RUN/PAUSE FSM, four scan modes.
// Define LED_SCAN_BLINK_EN to flash each position at 50% duty while running.
module led_scan_ctrl #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] mode,
  output logic [2:0] sel,
  output logic       dec_en,
  output logic       busy,
  output logic       cycle_done
);

  localparam int unsigned   CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
`ifdef LED_SCAN_BLINK_EN
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);
`endif

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic          dir_q, dir_d;
  logic [1:0]    mode_q, mode_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick;

  assign tick = (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // dir_q: 0 = up, 1 = down; only meaningful for the ping-pong mode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_d = 3'd0;
        cnt_d = '0;
        dir_d = 1'b0;
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          if (mode == 2'b01) begin
            sel_d = 3'd7;
            dir_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          sel_d   = 3'd0;
          cnt_d   = '0;
          dir_d   = 1'b0;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (!tick) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          case (mode_q)
            2'b00: begin
              sel_d  = sel_q + 3'd1;
              done_d = (sel_q == 3'd7);
            end
            2'b01: begin
              sel_d  = sel_q - 3'd1;
              done_d = (sel_q == 3'd0);
            end
            2'b10: begin
              sel_d  = dir_q ? (sel_q - 3'd1) : (sel_q + 3'd1);
              done_d = dir_q && (sel_q == 3'd1);
              // Turn around on arrival so each endpoint dwells one period only
              if (!dir_q && sel_q == 3'd6) dir_d = 1'b1;
              if (dir_q && sel_q == 3'd1)  dir_d = 1'b0;
            end
            default: begin
              if (sel_q == 3'd7) begin
                done_d  = 1'b1;
                state_d = IDLE;
                sel_d   = 3'd0;
              end else begin
                sel_d = sel_q + 3'd1;
              end
            end
          endcase
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          sel_d   = 3'd0;
          cnt_d   = '0;
          dir_d   = 1'b0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 3'd0;
        cnt_d   = '0;
        dir_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d != IDLE);
`ifdef LED_SCAN_BLINK_EN
    case (state_d)
      RUN:     en_d = (cnt_d < CNT_HALF);
      PAUSE:   en_d = en_q;
      default: en_d = 1'b0;
    endcase
`else
    en_d = busy_d;
`endif
  end

  assign sel        = sel_q;
  assign dec_en     = en_q;
  assign busy       = busy_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomized self-checking bench for led_scan_ctrl against a table-driven scan reference model.
module tb_led_scan_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       dec_en, busy, cycle_done;

  int vecCount = 0;
  int missCount = 0;

  // Reference model: 0 idle, 1 run, 2 pause; idx = position within the mode's scan cycle
  int m_st, m_mode, m_idx, m_ph;
  bit m_done;

  led_scan_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .mode(mode),
    .sel(sel), .dec_en(dec_en), .busy(busy), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  function automatic int seqLen(input int md);
    return (md == 2) ? 14 : 8;
  endfunction

  function automatic int seqPos(input int md, input int idx);
    case (md)
      0:       return idx;
      1:       return 7 - idx;
      2:       return (idx <= 7) ? idx : 14 - idx;
      default: return idx;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep();
    m_done = 1'b0;
    if (rst) begin
      m_st = 0; m_mode = 0; m_idx = 0; m_ph = 0;
    end else begin
      case (m_st)
        0: if (start && !stop) begin
             m_st = 1; m_mode = int'(mode); m_idx = 0; m_ph = 0;
           end
        1: if (stop) m_st = 0;
           else if (pause) m_st = 2;
           else if (m_ph == TD - 1) begin
             m_ph = 0;
             m_idx++;
             if (m_idx == seqLen(m_mode)) begin
               m_done = 1'b1;
               m_idx  = 0;
               if (m_mode == 3) m_st = 0;
             end
           end else m_ph++;
        default: if (stop) m_st = 0;
                 else if (!pause) m_st = 1;
      endcase
    end
  endtask

  task automatic checkAll();
    logic [7:0] eSel, eEn;
    eSel = (m_st == 0) ? 8'd0 : 8'(seqPos(m_mode, m_idx));
`ifdef LED_SCAN_BLINK_EN
    eEn = (m_st != 0 && m_ph < TD / 2) ? 8'd1 : 8'd0;
`else
    eEn = (m_st != 0) ? 8'd1 : 8'd0;
`endif
    checkOutput("sel", 8'(sel), eSel);
    checkOutput("dec_en", 8'(dec_en), eEn);
    checkOutput("busy", 8'(busy), (m_st != 0) ? 8'd1 : 8'd0);
    checkOutput("cycle_done", 8'(cycle_done), 8'(m_done));
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic t, input logic p,
                               input logic [1:0] m);
    @(negedge clk);
    rst = r; start = s; stop = t; pause = p; mode = m;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, m);
  endtask

  // Runs until the model reaches the given phase (and index if >= 0), bounded
  task automatic runUntil(input int ph, input int idx);
    int n;
    n = 0;
    while (!(m_st == 1 && m_ph == ph && (idx < 0 || m_idx == idx)) && n < 200) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      n++;
    end
    if (n >= 200) checkOutput("wait_bound", 8'd0, 8'd1);
  endtask

  initial begin
    logic r, s, t, p;
    logic [1:0] m;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'b00;
    m_st = 0; m_mode = 0; m_idx = 0; m_ph = 0; m_done = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

    // Each mode for more than one full scan cycle, start dropped after one clk
    for (int md = 0; md < 4; md++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'(md));
      idleCycles((md == 2) ? 130 : 70, 2'(3 - md));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    end

    // Pause mid-position at sel=3, then release
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    runUntil(1, 3);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    idleCycles(10, 2'b00);

    // Pause coincident with a tick
    runUntil(TD - 1, -1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    idleCycles(6, 2'b00);

    // Stop coincident with a tick at the 7->0 wrap
    runUntil(TD - 1, 7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    idleCycles(3, 2'b00);

    // Single sweep with start held: restarts after one idle clk
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11);

    // Reset mid-run
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
    idleCycles(9, 2'b10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    idleCycles(2, 2'b00);

    // Randomized traffic
    p = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      t = ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) p = ~p;
      m = 2'($urandom_range(0, 3));
      applyStimulus(r, s, t, p, m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Sequencer for the 3-to-8 one-hot LED decoder: drives its select lines and enable so that one LED at a time steps across the bar.
- Contains a tick prescaler, a run/pause/idle state machine and a position/direction engine with four scan modes.
- Sits between board buttons/switches (start, stop, pause, mode) and the decoder; decoder inputs {C,B,A} = sel[2:0], Enable = dec_en.

Parameters:
- TICK_DIV, 25000000, clk cycles per LED step; legal range 2..2^26; prescaler width = clog2(TICK_DIV).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE only.
- stop  in  1  level; returns to IDLE from any state.
- pause  in  1  level; holds position while high.
- mode  in  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 single sweep; latched on start.
- sel  out  3  decoder select, registered.
- dec_en  out  1  decoder enable, registered.
- busy  out  1  high in RUN or PAUSE.
- cycle_done  out  1  one-clk pulse at end of each full scan cycle.

Behaviour:
- Reset, synchronous, active-high; rst wins over all inputs: state=IDLE, sel=0, dec_en=0, busy=0, cycle_done=0, prescaler=0, dir=up, latched mode=00.
- States: IDLE, RUN, PAUSE. Input priority: stop > pause > start.
- IDLE: dec_en=0, sel=0. On start=1 (stop=0): latch mode, go RUN next clk. Load sel=7 and dir=down for mode 01; otherwise sel=0, dir=up. Clear prescaler, set dec_en=1.
- RUN: prescaler counts 0..TICK_DIV-1. tick = (count==TICK_DIV-1); prescaler wraps to 0 on tick. sel advances on the clk edge where tick=1, so each position is displayed exactly TICK_DIV clks.
  - pause=1 -> PAUSE.
  - stop=1 -> IDLE, with the IDLE outputs above.
- PAUSE: prescaler, sel and dir frozen; dec_en stays 1. pause=0 -> RUN, resuming count from the frozen value. stop=1 -> IDLE.
- Step rules on tick:
  - mode 00: sel+1 mod 8. 7->0 asserts cycle_done.
  - mode 01: sel-1 mod 8. 0->7 asserts cycle_done.
  - mode 10 (ping-pong): up until 7, then 6 with dir=down. Down until 0, then 1 with dir=up. cycle_done on the 1->0 step. Endpoints 0 and 7 each show for one period only; no double dwell.
  - mode 11 (single sweep): 0..7 up. On the tick while sel=7: cycle_done=1, go IDLE (sel=0, dec_en=0, busy=0).
- cycle_done is registered and coincident with the sel update edge; high for exactly 1 clk.
- mode changes while busy are ignored until the next start.
- start held high in RUN/PAUSE is ignored.
- After single-sweep completion with start still high, RUN restarts the following clk: IDLE is held for 1 clk.
- stop and tick on the same clk: stop wins, no step, no cycle_done.
- pause and tick on the same clk: PAUSE entered, no step. The frozen count stays at TICK_DIV-1, so the step occurs on the first RUN clk after release.
- Outputs are glitch-free (all registered); dec_en never high in IDLE.

Optional Feature:
- Macro LED_SCAN_BLINK_EN.
- Defined: in RUN only, dec_en = 1 while prescaler < TICK_DIV/2 (integer divide), else 0, giving a 50% flash per position. In PAUSE, dec_en is held at its last value.
- Undefined: dec_en is constant 1 in RUN and PAUSE.
- All other behaviour is identical in both builds.

Test Plan (TICK_DIV=4):
- rst 3 clks then release -> sel=0, dec_en=0, busy=0, cycle_done=0. start=1 with mode=00 -> next clk busy=1, dec_en=1, sel=0. sel then reads 1,2,...,7,0 every 4 clks, with cycle_done pulsing 1 clk at the 7->0 edge.
- mode=01 start -> sel=7 first. Sequence 7,6,...,0,7; cycle_done at 0->7.
- mode=10 start -> sequence 0..7,6..1,0 at 4 clks each (14 steps per cycle); cycle_done only at the 1->0 edge.
- mode=11 start, start dropped after 1 clk -> 0..7 shown. On the tick at 7: cycle_done=1, then busy=0, dec_en=0, sel=0; stays idle.
- Pause and stop:
  - In mode 00 at sel=3, raise pause for 10 clks -> sel=3 held, dec_en=1. After release, the remaining count completes before sel=4.
  - stop asserted on a tick clk -> IDLE next clk, sel=0, no cycle_done.
  - rst asserted mid-RUN -> all outputs at reset values next clk.
- With LED_SCAN_BLINK_EN: mode 00 run -> dec_en pattern 1,1,0,0 per position. Without the macro: dec_en steady 1.
